player_anim_sequencer: RTL and testbench
========================================

# player_anim_sequencer

Parametrised per-player animation sequencer; the next generation of the fixed-priority animation selector. It chooses the animation state from the hitstun, attack, jump and move requests. It also generates frame indices internally for idle, walk and hitstun, with a configurable tick rate, looping versus one-shot behaviour and event pulses. It sits between the gameplay modules (resolver, attack, move) and the sprite renderer, and advances only on SCEN game ticks.

## Interface
- FRAME_W, 6: width of all frame indices
- TICK_W, 4: width of the internal tick divider
- TICKS_PER_FRAME, 4: SCEN ticks per internal frame step; 1..2^TICK_W
- IDLE_FRAMES, 4: idle loop length; 1..2^FRAME_W
- WALK_FRAMES, 6: walk loop length; 1..2^FRAME_W
- HIT_FRAMES, 3: hitstun one-shot length; 1..2^FRAME_W

Ports:
- clk  in  1  single system clock
- reset_n  in  1  synchronous, active-low reset
- SCEN  in  1  game-tick enable; state and counters change only when high
- hitstun_active  in  1  from resolver
- attack_active  in  1  from attack module
- attack_type  in  2  encoding: 0 or 1 → ATK1, 2 → ATK2, 3 → ATK3
- attack_frame  in  FRAME_W  external attack frame
- move_active  in  1  from move module
- jump_active  in  1  from move module
- jump_frame  in  FRAME_W  external jump frame
- anim_state  out  4  current animation state code
- anim_frame  out  FRAME_W  current frame index
- anim_changed  out  1  one-clk pulse when anim_state changes
- loop_wrap  out  1  one-clk pulse when IDLE or WALK wraps to frame 0
- hit_done  out  1  one-clk pulse when HIT reaches its last frame

## Operation
- State codes: IDLE=0, WALK=1, JUMP=2, ATK1=3, ATK2=4, HIT=5, ATK3=6. Codes 7..15 are never produced.
- Request priority, evaluated every SCEN cycle: hitstun_active > attack_active > jump_active > move_active > idle.
- External states (ATK1/2/3, JUMP):
  - anim_frame <= attack_frame or jump_frame on every SCEN cycle.
  - Internal counters are held at 0.
- Internal states (IDLE, WALK, HIT) keep a tick counter and a frame counter:
  - On each SCEN cycle the tick counter increments.
  - When the tick counter equals TICKS_PER_FRAME-1, it clears to 0 and the frame steps.
- Frame step in IDLE and WALK:
  - From frame N-1 the next frame is 0, and loop_wrap pulses.
  - Otherwise the frame increments by 1.
- Frame step in HIT:
  - Increment until HIT_FRAMES-1, then hold there while hitstun persists.
  - hit_done pulses on the step that enters HIT_FRAMES-1.
  - If HIT_FRAMES=1, hit_done pulses on the first completed frame period.
- State change (next state differs from anim_state, SCEN high):
  - anim_state <= next state; anim_changed <= 1.
  - Tick and frame counters clear to 0.
  - anim_frame <= the external frame if the new state is external, otherwise 0.
- Same state re-requested, e.g. ATK1 followed by ATK1: no anim_changed, counters continue.
- attack_type changing while attack_active stays high counts as a state change (ATK1 → ATK2).

## Timing
- Reset (reset_n low at a clk edge) overrides SCEN. Reset values:
  - anim_state=IDLE, anim_frame=0, all pulses 0, counters 0.
- Outputs are registered; latency is one clk from the sampled inputs on an SCEN cycle.
- anim_changed, loop_wrap and hit_done:
  - Assert for exactly one clk and clear on the next clk whether or not SCEN is high.
  - anim_changed and loop_wrap cannot both fire on the same cycle, because a change clears the counters.
- SCEN low: anim_state, anim_frame and the counters hold; inputs are ignored.
- Reset asserted mid-animation: the next cycle shows reset values with no pulse. The first SCEN after release evaluates from IDLE with counters at 0.
- All counters are unsigned. Compares against N-1 use parameter-derived constants truncated to the counter width; no overflow is possible within the legal parameter ranges.

## Structure
- Shared package anim_pkg holds the state code localparams (S_IDLE..S_ATK3) and the attack_type decode constants. The renderer imports the same package.
- One sub-module, anim_frame_timer, holds the tick divider and the frame counter, with parameters TICK_W, FRAME_W and TICKS_PER_FRAME.
  - Inputs: step_en, clear, loop, length.
  - Outputs: frame, wrap, last.
  - The top level contains the priority arbiter, the state register, the output mux and the pulse registers.

## Test plan
All scenarios use default parameters and SCEN held high unless stated.
1. Reset with no requests, then 16 SCEN cycles → anim_frame steps 0,1,2,3,0 every 4 ticks; loop_wrap pulses once on the 3→0 step; anim_state=0 throughout.
2. move_active=1 from idle → next clk anim_state=1, anim_changed=1 for one clk, anim_frame=0; after 24 ticks the frame has wrapped 5→0 once.
3. hitstun_active=1 and attack_active=1 together → anim_state=5. After 8 ticks anim_frame=2 and hit_done pulses once; after 20 ticks anim_frame is still 2.
4. attack_active=1, attack_type=2, attack_frame=13, then attack_type=3 mid-attack → anim_state 4 with anim_frame=13, then anim_state 6 with a second anim_changed pulse.
5. SCEN pulsed high only every 3rd clk in WALK → frame steps every 12 clks; outputs are stable between SCEN pulses; each pulse is one clk wide.
6. reset_n driven low mid-HIT at frame 1, with SCEN low → the next clk shows anim_state=0, anim_frame=0 and all pulses 0.

Source files
------------

// File: rtl/anim_pkg.sv
// anim_pkg
//   Shared definitions for the player animation sequencer and the sprite
//   renderer: animation state codes and attack_type decode constants.
//   Codes 7..15 of the 4-bit state field are never produced.
package anim_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5,
        S_ATK3 = 4'd6
    } anim_state_e;

    // attack_type decode: 0 and 1 both select ATK1.
    localparam logic [1:0] ATK_TYPE_2 = 2'd2;
    localparam logic [1:0] ATK_TYPE_3 = 2'd3;

    // External states take their frame index from a gameplay module
    // instead of the internal frame timer.
    function automatic logic is_external(anim_state_e s);
        return (s == S_JUMP) || (s == S_ATK1) || (s == S_ATK2) || (s == S_ATK3);
    endfunction

endpackage

// File: rtl/player_anim_sequencer_if.sv
// player_anim_sequencer_if
//   Bundles the gameplay-facing request signals and the renderer-facing
//   animation outputs of one player's sequencer.
//   master : gameplay side (drives requests, observes animation outputs)
//   slave  : the sequencer (observes requests, drives animation outputs)
//
//   There is no valid/ready handshake here: requests are level signals that
//   are sampled only on SCEN cycles, and the outputs are registered levels
//   plus single-clock event pulses (anim_changed, loop_wrap, hit_done).
interface player_anim_sequencer_if #(
    parameter int FRAME_W = 6
);
    logic               hitstun_active;
    logic               attack_active;
    logic [1:0]         attack_type;
    logic [FRAME_W-1:0] attack_frame;
    logic               move_active;
    logic               jump_active;
    logic [FRAME_W-1:0] jump_frame;

    logic [3:0]         anim_state;
    logic [FRAME_W-1:0] anim_frame;
    logic               anim_changed;
    logic               loop_wrap;
    logic               hit_done;

    modport master (
        output hitstun_active, attack_active, attack_type, attack_frame,
               move_active, jump_active, jump_frame,
        input  anim_state, anim_frame, anim_changed, loop_wrap, hit_done
    );

    modport slave (
        input  hitstun_active, attack_active, attack_type, attack_frame,
               move_active, jump_active, jump_frame,
        output anim_state, anim_frame, anim_changed, loop_wrap, hit_done
    );
endinterface

// File: rtl/anim_frame_timer.sv
// anim_frame_timer
//   Tick divider plus frame counter for the internally timed animations.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     step_en      : advance the tick divider this clock
//     clear        : force tick and frame to 0 (wins over step_en)
//     loop         : 1 = wrap to frame 0 after the last frame, 0 = hold
//     length       : number of frames in the current animation (1..2^FRAME_W)
//     frame        : current frame index
//     wrap         : combinational, this step wraps a looping animation to 0
//     last         : combinational, this step completes a one-shot animation
module anim_frame_timer #(
    parameter int TICK_W          = 4,
    parameter int FRAME_W         = 6,
    parameter int TICKS_PER_FRAME = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               step_en,
    input  logic               clear,
    input  logic               loop,
    input  logic [FRAME_W:0]   length,
    output logic [FRAME_W-1:0] frame,
    output logic               wrap,
    output logic               last
);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [FRAME_W:0]   ONE       = (FRAME_W + 1)'(1);

    logic [TICK_W-1:0]  tick_q;
    logic [FRAME_W-1:0] frame_q;
    logic               held_q;   // one-shot has already reported completion

    logic               period_done;
    logic [FRAME_W:0]   last_idx;
    logic [FRAME_W:0]   frame_inc;
    logic               at_end;

    assign period_done = step_en && (tick_q == TICK_LAST);
    assign last_idx    = length - ONE;
    assign frame_inc   = {1'b0, frame_q} + ONE;
    assign at_end      = ({1'b0, frame_q} == last_idx);

    assign wrap  = period_done && loop && at_end;
    // at_end with held_q clear only happens for a one-frame animation, whose
    // first completed period is its completion.
    assign last  = period_done && !loop && !held_q && (at_end || (frame_inc == last_idx));
    assign frame = frame_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            tick_q  <= '0;
            frame_q <= '0;
            held_q  <= 1'b0;
        end else if (step_en) begin
            if (period_done) begin
                tick_q <= '0;
                if (at_end) begin
                    if (loop) begin
                        frame_q <= '0;
                    end
                end else begin
                    frame_q <= frame_inc[FRAME_W-1:0];
                end
                if (last) begin
                    held_q <= 1'b1;
                end
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer
//   Per-player animation state selector and frame sequencer. Picks the
//   animation from the gameplay requests with fixed priority
//   (hitstun > attack > jump > move > idle) and produces the frame index:
//   copied from the gameplay module for JUMP/ATK*, generated by
//   anim_frame_timer for IDLE/WALK (looping) and HIT (one-shot).
//   Everything advances only on SCEN game ticks.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset (overrides SCEN)
//     SCEN         : game-tick enable
//     bus          : request inputs and animation outputs (slave modport)
//   The anim_state output is the FSM state register itself.
module player_anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_W         = 6,
    parameter int TICK_W          = 4,
    parameter int TICKS_PER_FRAME = 4,
    parameter int IDLE_FRAMES     = 4,
    parameter int WALK_FRAMES     = 6,
    parameter int HIT_FRAMES      = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SCEN,
    player_anim_sequencer_if.slave bus
);

    localparam logic [FRAME_W:0] IDLE_LEN = (FRAME_W + 1)'(IDLE_FRAMES);
    localparam logic [FRAME_W:0] WALK_LEN = (FRAME_W + 1)'(WALK_FRAMES);
    localparam logic [FRAME_W:0] HIT_LEN  = (FRAME_W + 1)'(HIT_FRAMES);

    anim_state_e        state_q;
    anim_state_e        next_state;
    logic [FRAME_W-1:0] ext_frame_q;
    logic [FRAME_W-1:0] ext_sel;
    logic               state_change;
    logic               next_is_ext;

    logic               anim_changed_q;
    logic               loop_wrap_q;
    logic               hit_done_q;

    logic               timer_clear;
    logic               timer_step;
    logic               timer_loop;
    logic [FRAME_W:0]   timer_len;
    logic [FRAME_W-1:0] timer_frame;
    logic               timer_wrap;
    logic               timer_last;

    // Priority arbiter.
    always_comb begin
        next_state = S_IDLE;
        if (bus.hitstun_active) begin
            next_state = S_HIT;
        end else if (bus.attack_active) begin
            case (bus.attack_type)
                ATK_TYPE_3: next_state = S_ATK3;
                ATK_TYPE_2: next_state = S_ATK2;
                default:    next_state = S_ATK1;
            endcase
        end else if (bus.jump_active) begin
            next_state = S_JUMP;
        end else if (bus.move_active) begin
            next_state = S_WALK;
        end
    end

    assign state_change = SCEN && (next_state != state_q);
    assign next_is_ext  = is_external(next_state);
    assign ext_sel      = (next_state == S_JUMP) ? bus.jump_frame : bus.attack_frame;

    // Counters restart on any change and stay at 0 while in an external state.
    assign timer_clear  = SCEN && (state_change || next_is_ext);
    assign timer_step   = SCEN && !timer_clear;
    assign timer_loop   = (state_q == S_IDLE) || (state_q == S_WALK);

    always_comb begin
        timer_len = HIT_LEN;
        if (state_q == S_IDLE) begin
            timer_len = IDLE_LEN;
        end else if (state_q == S_WALK) begin
            timer_len = WALK_LEN;
        end
    end

    anim_frame_timer #(
        .TICK_W          (TICK_W),
        .FRAME_W         (FRAME_W),
        .TICKS_PER_FRAME (TICKS_PER_FRAME)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .step_en (timer_step),
        .clear   (timer_clear),
        .loop    (timer_loop),
        .length  (timer_len),
        .frame   (timer_frame),
        .wrap    (timer_wrap),
        .last    (timer_last)
    );

    // State register, external frame latch and pulse registers. The pulse
    // sources are all gated by SCEN, so each pulse drops on the next clock.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            ext_frame_q    <= '0;
            anim_changed_q <= 1'b0;
            loop_wrap_q    <= 1'b0;
            hit_done_q     <= 1'b0;
        end else begin
            anim_changed_q <= state_change;
            loop_wrap_q    <= timer_wrap;
            hit_done_q     <= timer_last;
            if (SCEN) begin
                state_q <= next_state;
                if (next_is_ext) begin
                    ext_frame_q <= ext_sel;
                end
            end
        end
    end

    assign bus.anim_state   = state_q;
    assign bus.anim_frame   = is_external(state_q) ? ext_frame_q : timer_frame;
    assign bus.anim_changed = anim_changed_q;
    assign bus.loop_wrap    = loop_wrap_q;
    assign bus.hit_done     = hit_done_q;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Self-checking bench for player_anim_sequencer (default parameters).
module tb_player_anim_sequencer;

    localparam int FRAME_W = 6;
    localparam int TPF     = 4;
    localparam int N_IDLE  = 4;
    localparam int N_WALK  = 6;
    localparam int N_HIT   = 3;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scen = 1'b0;
    always #5 clk = ~clk;

    player_anim_sequencer_if #(.FRAME_W(FRAME_W)) bus ();

    player_anim_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .SCEN    (scen),
        .bus     (bus)
    );

    // scoreboard counters
    int n_cmp = 0;
    int n_err = 0;
    int wrap_cnt = 0;
    int hit_cnt = 0;
    int chg_cnt = 0;

    // reference model: animation code, SCEN ticks spent in it, outputs
    int m_state = 0;
    int m_ticks = 0;
    int m_frame = 0;
    int m_changed = 0;
    int m_wrap = 0;
    int m_hit = 0;

    function automatic int requested();
        if (bus.hitstun_active) return 5;
        if (bus.attack_active) begin
            if (bus.attack_type == 2'd3) return 6;
            if (bus.attack_type == 2'd2) return 4;
            return 3;
        end
        if (bus.jump_active) return 2;
        if (bus.move_active) return 1;
        return 0;
    endfunction

    function automatic int ext_frame_of(int s);
        if (s == 2) return int'(bus.jump_frame);
        return int'(bus.attack_frame);
    endfunction

    function automatic bit is_ext(int s);
        return (s == 2) || (s == 3) || (s == 4) || (s == 6);
    endfunction

    // Frame index follows from the number of whole frame periods elapsed.
    task automatic model_step();
        int ns;
        int p;
        m_changed = 0;
        m_wrap = 0;
        m_hit = 0;
        if (!reset_n) begin
            m_state = 0;
            m_ticks = 0;
            m_frame = 0;
        end else if (scen) begin
            ns = requested();
            if (ns != m_state) begin
                m_state = ns;
                m_ticks = 0;
                m_changed = 1;
                m_frame = is_ext(ns) ? ext_frame_of(ns) : 0;
            end else if (is_ext(m_state)) begin
                m_frame = ext_frame_of(m_state);
            end else begin
                m_ticks++;
                if (m_ticks % TPF == 0) begin
                    p = m_ticks / TPF;
                    if (m_state == 5) begin
                        m_frame = (p < N_HIT - 1) ? p : N_HIT - 1;
                        m_hit = (p == ((N_HIT > 1) ? N_HIT - 1 : 1)) ? 1 : 0;
                    end else begin
                        int n;
                        n = (m_state == 0) ? N_IDLE : N_WALK;
                        m_frame = p % n;
                        m_wrap = (p % n == 0) ? 1 : 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("anim_state", 32'(bus.anim_state), 32'(m_state));
        chk("anim_frame", 32'(bus.anim_frame), 32'(m_frame));
        chk("anim_changed", 32'(bus.anim_changed), 32'(m_changed));
        chk("loop_wrap", 32'(bus.loop_wrap), 32'(m_wrap));
        chk("hit_done", 32'(bus.hit_done), 32'(m_hit));
        if (bus.loop_wrap === 1'b1) wrap_cnt++;
        if (bus.hit_done === 1'b1) hit_cnt++;
        if (bus.anim_changed === 1'b1) chg_cnt++;
    endtask

    // driver: model sees the inputs about to be sampled, DUT clocks, compare
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_requests();
        bus.hitstun_active = 1'b0;
        bus.attack_active  = 1'b0;
        bus.attack_type    = 2'd0;
        bus.attack_frame   = '0;
        bus.move_active    = 1'b0;
        bus.jump_active    = 1'b0;
        bus.jump_frame     = '0;
    endtask

    initial begin
        clear_requests();

        // reset with no requests
        reset_n = 1'b0;
        scen = 1'b1;
        repeat (2) cycle();
        chk("reset_state", 32'(bus.anim_state), 32'd0);
        reset_n = 1'b1;

        // 1: idle loop over 16 ticks
        wrap_cnt = 0;
        repeat (16) cycle();
        chk("idle_wrap_count", 32'(wrap_cnt), 32'd1);
        chk("idle_frame_end", 32'(bus.anim_frame), 32'd0);

        // 2: walk from idle
        bus.move_active = 1'b1;
        cycle();
        chk("walk_enter_state", 32'(bus.anim_state), 32'd1);
        chk("walk_enter_changed", 32'(bus.anim_changed), 32'd1);
        wrap_cnt = 0;
        repeat (24) cycle();
        chk("walk_wrap_count", 32'(wrap_cnt), 32'd1);

        // 3: hitstun beats attack; one-shot holds on its last frame
        bus.move_active = 1'b0;
        bus.hitstun_active = 1'b1;
        bus.attack_active = 1'b1;
        cycle();
        chk("hit_enter_state", 32'(bus.anim_state), 32'd5);
        hit_cnt = 0;
        repeat (8) cycle();
        chk("hit_frame_8", 32'(bus.anim_frame), 32'd2);
        repeat (12) cycle();
        chk("hit_frame_20", 32'(bus.anim_frame), 32'd2);
        chk("hit_done_count", 32'(hit_cnt), 32'd1);

        // 4: attack type switch mid-attack
        bus.hitstun_active = 1'b0;
        bus.attack_type = 2'd2;
        bus.attack_frame = 6'd13;
        chg_cnt = 0;
        repeat (3) cycle();
        chk("atk2_frame", 32'(bus.anim_frame), 32'd13);
        bus.attack_type = 2'd3;
        repeat (3) cycle();
        chk("atk3_state", 32'(bus.anim_state), 32'd6);
        chk("atk_change_count", 32'(chg_cnt), 32'd2);

        // 5: walk with SCEN every 3rd clock
        bus.attack_active = 1'b0;
        bus.move_active = 1'b1;
        scen = 1'b1;
        cycle();
        for (int i = 0; i < 48; i++) begin
            scen = (i % 3 == 2);
            cycle();
        end

        // 6: reset mid-HIT with SCEN low
        scen = 1'b1;
        bus.move_active = 1'b0;
        bus.hitstun_active = 1'b1;
        repeat (5) cycle();
        chk("hit_frame_before_reset", 32'(bus.anim_frame), 32'd1);
        scen = 1'b0;
        reset_n = 1'b0;
        cycle();
        chk("reset_mid_hit_state", 32'(bus.anim_state), 32'd0);
        reset_n = 1'b1;
        bus.hitstun_active = 1'b0;
        scen = 1'b1;
        repeat (3) cycle();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            scen    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 23) == 0) bus.hitstun_active = ~bus.hitstun_active;
            if ($urandom_range(0, 15) == 0) bus.attack_active  = ~bus.attack_active;
            if ($urandom_range(0, 15) == 0) bus.jump_active    = ~bus.jump_active;
            if ($urandom_range(0, 11) == 0) bus.move_active    = ~bus.move_active;
            if ($urandom_range(0, 9) == 0)  bus.attack_type    = 2'($urandom_range(0, 3));
            bus.attack_frame = FRAME_W'($urandom);
            bus.jump_frame   = FRAME_W'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
